// File: rtl/load_response_unit_pkg.sv
// Shared types and constants for the load response unit.
// Holds load funct3 encodings and the queued request record.
package load_response_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int LRU_ADDR_W = 32;
  localparam int LRU_ROB_W  = 5;
  localparam int LRU_PHY_W  = 6;

  typedef struct packed {
    logic [LRU_ADDR_W-1:0] addr;
    logic [2:0]            funct3;
    logic [LRU_ROB_W-1:0]  rob_id;
    logic [LRU_PHY_W-1:0]  rd_phy;
  } load_req_t;

endpackage

// File: rtl/load_response_unit_align.sv
// Load lane extraction: word + byte offset + funct3 -> extended data, exc.
// Ports: word, lane (addr[1:0]), funct3 in; data (0 on exc), exc out.
module load_align
  import load_response_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        exc
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane[1] ? word[31:16] : word[15:0];
    data    = '0;
    exc     = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_v[7]}}, byte_v};
      F3_LBU: data = {24'd0, byte_v};
      F3_LH: begin
        exc  = lane[0];
        data = {{16{half_v[15]}}, half_v};
      end
      F3_LHU: begin
        exc  = lane[0];
        data = {16'd0, half_v};
      end
      F3_LW: begin
        exc  = |lane;
        data = word;
      end
      default: exc = 1'b1;
    endcase
    if (exc) data = '0;
  end

endmodule

// File: rtl/load_response_unit.sv
// Load responder: queues loads, one memory read at a time, in-order wb.
// Ports: load_* in, lsu_busy out, mem_req_*/mem_resp_* memory side, wb_* out.
module load_response_unit
  import load_response_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int PHY_WIDTH  = 6,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_raddr,
  input  logic [2:0]            load_funct3,
  input  logic [ROB_WIDTH-1:0]  load_rob_id,
  input  logic [PHY_WIDTH-1:0]  load_rd_phy,
  output logic                  lsu_busy,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  wb_valid,
  output logic [ROB_WIDTH-1:0]  wb_rob_id,
  output logic [PHY_WIDTH-1:0]  wb_rd_phy,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_exc,
  input  logic                  wb_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  load_req_t        q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [2:0]       state;
  logic [2:0]       state_nxt;

  load_req_t   head;
  logic        empty;
  logic        push;
  logic        pop;
  logic        issue;
  logic [31:0] align_data;
  logic        align_exc;

  assign head     = q[rd_ptr];
  assign empty    = (count == '0);
  assign lsu_busy = (count == FULL);
  assign push     = load_valid && !lsu_busy && !flush;
  assign pop      = (state == S_RESP) && wb_ready;
  assign wb_valid = (state == S_RESP);

  // IDLE issues directly so a fresh load reaches memory the cycle after push.
  assign mem_req_valid = !empty && !align_exc &&
                         (state == S_IDLE || state == S_REQ);
  assign issue         = mem_req_valid && mem_req_ready;
  assign mem_req_addr  = mem_req_valid ?
                         {head.addr[ADDR_WIDTH-1:2], 2'b00} : '0;

  load_align u_align (
    .word   (mem_resp_data),
    .lane   (head.addr[1:0]),
    .funct3 (head.funct3),
    .data   (align_data),
    .exc    (align_exc)
  );

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // A request already accepted owes one response; swallow it.
      if (issue ||
          ((state == S_WAIT || state == S_DRAIN) && !mem_resp_valid))
        state_nxt = S_DRAIN;
      else
        state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:
          if (!empty)
            state_nxt = align_exc ? S_RESP :
                        (mem_req_ready ? S_WAIT : S_REQ);
        S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
        S_WAIT:  if (mem_resp_valid) state_nxt = S_RESP;
        S_RESP:  if (wb_ready) state_nxt = S_IDLE;
        S_DRAIN: if (mem_resp_valid) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      q[wr_ptr] <= '{addr:   load_raddr,
                     funct3: load_funct3,
                     rob_id: load_rob_id,
                     rd_phy: load_rd_phy};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= S_IDLE;
      wb_rob_id <= '0;
      wb_rd_phy <= '0;
      wb_data   <= '0;
      wb_exc    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        if (state == S_IDLE && !empty && align_exc) begin
          wb_rob_id <= head.rob_id;
          wb_rd_phy <= head.rd_phy;
          wb_data   <= '0;
          wb_exc    <= 1'b1;
        end else if (state == S_WAIT && mem_resp_valid) begin
          wb_rob_id <= head.rob_id;
          wb_rd_phy <= head.rd_phy;
          wb_data   <= align_data;
          wb_exc    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_response_unit.sv
// Self-checking bench for load_response_unit.
// Table of single loads plus backpressure, flush and reset sequences.
module tb_load_response_unit;
  import load_response_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_raddr = '0;
  logic [2:0]  load_funct3 = '0;
  logic [4:0]  load_rob_id = '0;
  logic [5:0]  load_rd_phy = '0;
  logic        lsu_busy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_valid;
  logic [4:0]  wb_rob_id;
  logic [5:0]  wb_rd_phy;
  logic [31:0] wb_data;
  logic        wb_exc;
  logic        wb_ready = 1'b1;

  logic        auto_mem = 1'b0;
  logic        rsp_q = 1'b0;
  logic [31:0] rsp_data_q = '0;
  logic        man_resp_valid = 1'b0;
  logic [31:0] man_resp_data = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_resp_valid = auto_mem ? rsp_q : man_resp_valid;
  assign mem_resp_data  = auto_mem ? rsp_data_q : man_resp_data;

  // One-cycle-latency memory: data derived from the word address.
  always @(posedge clk) begin
    rsp_q      <= auto_mem && mem_req_valid && mem_req_ready;
    rsp_data_q <= 32'hA000_0000 ^ mem_req_addr;
  end

  load_response_unit dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .load_valid     (load_valid),
    .load_raddr     (load_raddr),
    .load_funct3    (load_funct3),
    .load_rob_id    (load_rob_id),
    .load_rd_phy    (load_rd_phy),
    .lsu_busy       (lsu_busy),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .wb_valid       (wb_valid),
    .wb_rob_id      (wb_rob_id),
    .wb_rd_phy      (wb_rd_phy),
    .wb_data        (wb_data),
    .wb_exc         (wb_exc),
    .wb_ready       (wb_ready)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t vt [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] rob, input logic [5:0] rd);
    load_valid  = 1'b1;
    load_funct3 = f3;
    load_raddr  = a;
    load_rob_id = rob;
    load_rd_phy = rd;
  endtask

  task automatic wait_wb(input string nm);
    int t;
    t = 0;
    while (!wb_valid && t < 20) begin
      step();
      t++;
    end
    chk(nm, 32'(wb_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    vt[0]  = '{F3_LW,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vt[1]  = '{F3_LB,  32'h103, 32'h80FF0000, 32'hFFFFFF80, 1'b0};
    vt[2]  = '{F3_LBU, 32'h103, 32'h80FF0000, 32'h00000080, 1'b0};
    vt[3]  = '{F3_LH,  32'h102, 32'h80FF0000, 32'hFFFF80FF, 1'b0};
    vt[4]  = '{F3_LHU, 32'h102, 32'h80FF0000, 32'h000080FF, 1'b0};
    vt[5]  = '{F3_LB,  32'h101, 32'h80FF0000, 32'h00000000, 1'b0};
    vt[6]  = '{F3_LB,  32'h102, 32'h80FF0000, 32'hFFFFFFFF, 1'b0};
    vt[7]  = '{F3_LBU, 32'h100, 32'h12345678, 32'h00000078, 1'b0};
    vt[8]  = '{F3_LH,  32'h100, 32'h12348765, 32'hFFFF8765, 1'b0};
    vt[9]  = '{F3_LHU, 32'h100, 32'h12348765, 32'h00008765, 1'b0};
    vt[10] = '{F3_LW,  32'h102, 32'h11111111, 32'h00000000, 1'b1};
    vt[11] = '{F3_LH,  32'h101, 32'h11111111, 32'h00000000, 1'b1};
    vt[12] = '{F3_LHU, 32'h103, 32'h11111111, 32'h00000000, 1'b1};
    vt[13] = '{3'b011, 32'h100, 32'h11111111, 32'h00000000, 1'b1};
    vt[14] = '{3'b110, 32'h100, 32'h11111111, 32'h00000000, 1'b1};
    vt[15] = '{3'b111, 32'h100, 32'h11111111, 32'h00000000, 1'b1};

    step();
    step();
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_exc", 32'(wb_exc), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rob", 32'(wb_rob_id), 32'd0);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      a = vt[i].addr;
      drive_load(vt[i].f3, a, 5'(i), 6'(i + 10));
      step();
      load_valid = 1'b0;
      chk($sformatf("v%0d_req_valid", i), 32'(mem_req_valid),
          32'(!vt[i].exp_exc));
      if (!vt[i].exp_exc) begin
        chk($sformatf("v%0d_req_addr", i), mem_req_addr,
            {a[31:2], 2'b00});
        step();
        man_resp_valid = 1'b1;
        man_resp_data  = vt[i].word;
        chk($sformatf("v%0d_early_wb", i), 32'(wb_valid), 32'd0);
        step();
        man_resp_valid = 1'b0;
      end else begin
        step();
        chk($sformatf("v%0d_exc_noreq", i), 32'(mem_req_valid), 32'd0);
      end
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].exp_data);
      chk($sformatf("v%0d_wb_exc", i), 32'(wb_exc), 32'(vt[i].exp_exc));
      chk($sformatf("v%0d_wb_rob", i), 32'(wb_rob_id), 32'(i));
      chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd_phy), 32'(i + 10));
      step();
      chk($sformatf("v%0d_wb_done", i), 32'(wb_valid), 32'd0);
    end

    // Fill queue with memory stalled, drop a fifth load.
    auto_mem = 1'b1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_load(F3_LW, 32'h200 + 32'(4 * k), 5'(20 + k), 6'(30 + k));
      step();
    end
    chk("bp_busy", 32'(lsu_busy), 32'd1);
    chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
    chk("bp_req_addr", mem_req_addr, 32'h200);
    drive_load(F3_LW, 32'h210, 5'd24, 6'd34);
    step();
    load_valid = 1'b0;
    chk("bp_busy_hold", 32'(lsu_busy), 32'd1);
    wb_ready = 1'b0;
    mem_req_ready = 1'b1;
    wait_wb("bp_first_seen");
    for (int h = 0; h < 3; h++) begin
      step();
      chk($sformatf("hold%0d_valid", h), 32'(wb_valid), 32'd1);
      chk($sformatf("hold%0d_data", h), wb_data, 32'hA000_0200);
      chk($sformatf("hold%0d_rob", h), 32'(wb_rob_id), 32'd20);
    end
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_wb($sformatf("bp%0d_seen", k));
      chk($sformatf("bp%0d_rob", k), 32'(wb_rob_id), 32'(20 + k));
      chk($sformatf("bp%0d_data", k), wb_data,
          32'hA000_0000 ^ (32'h200 + 32'(4 * k)));
      step();
    end
    repeat (5) step();
    chk("bp_dropped_none", 32'(wb_valid), 32'd0);
    chk("bp_busy_clear", 32'(lsu_busy), 32'd0);

    // Flush while waiting on memory; stale response must be swallowed.
    auto_mem = 1'b0;
    drive_load(F3_LW, 32'h300, 5'd5, 6'd5);
    step();
    load_valid = 1'b0;
    chk("fl_req_valid", 32'(mem_req_valid), 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_load(F3_LW, 32'h304, 5'd6, 6'd7);
    chk("fl_c3_wb", 32'(wb_valid), 32'd0);
    chk("fl_c3_req", 32'(mem_req_valid), 32'd0);
    step();
    load_valid = 1'b0;
    man_resp_valid = 1'b1;
    man_resp_data = 32'hBAD0_BAD0;
    chk("fl_drain_req", 32'(mem_req_valid), 32'd0);
    chk("fl_c4_wb", 32'(wb_valid), 32'd0);
    step();
    man_resp_valid = 1'b0;
    chk("fl_new_req", 32'(mem_req_valid), 32'd1);
    chk("fl_new_addr", mem_req_addr, 32'h304);
    chk("fl_c5_wb", 32'(wb_valid), 32'd0);
    step();
    man_resp_valid = 1'b1;
    man_resp_data = 32'h600D_600D;
    chk("fl_c6_wb", 32'(wb_valid), 32'd0);
    step();
    man_resp_valid = 1'b0;
    chk("fl_wb_valid", 32'(wb_valid), 32'd1);
    chk("fl_wb_rob", 32'(wb_rob_id), 32'd6);
    chk("fl_wb_data", wb_data, 32'h600D_600D);
    chk("fl_wb_exc", 32'(wb_exc), 32'd0);
    step();
    chk("fl_wb_done", 32'(wb_valid), 32'd0);

    // Reset while a result is pending and another load is queued.
    auto_mem = 1'b1;
    wb_ready = 1'b0;
    drive_load(F3_LW, 32'h400, 5'd9, 6'd9);
    step();
    drive_load(F3_LW, 32'h404, 5'd10, 6'd10);
    step();
    load_valid = 1'b0;
    wait_wb("rs_seen");
    rst = 1'b1;
    step();
    chk("rs_wb_valid", 32'(wb_valid), 32'd0);
    chk("rs_busy", 32'(lsu_busy), 32'd0);
    chk("rs_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rs_wb_data", wb_data, 32'd0);
    chk("rs_wb_rob", 32'(wb_rob_id), 32'd0);
    rst = 1'b0;
    wb_ready = 1'b1;
    repeat (4) step();
    chk("rs_empty_req", 32'(mem_req_valid), 32'd0);
    chk("rs_empty_wb", 32'(wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
